dpram_hs: RTL and testbench
===========================

# dpram_hs

Parametrised simple-dual-port RAM with independent valid/ready write and read-request ports, byte-write strobes, a registered read-response port with 2-entry backpressure buffering, and a defined same-address collision policy. It is the next-generation storage primitive for datapath buffers that need flow control. It replaces ad-hoc single-cycle RAM wrappers wherever the consumer can stall.

## Interface
- ADDR_WIDTH, 4, address bits; depth = 2**ADDR_WIDTH words
- DATA_WIDTH, 32, word width; must be a multiple of 8; NB = DATA_WIDTH/8 byte lanes
- RW_MODE, 0, same-cycle same-address collision policy: 0 = read-first (old data), 1 = write-first (new data)
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  asynchronous, active-low reset
- i_cs  in  1  chip select; when 0 no request is accepted on either port
- i_wvalid  in  1  write request valid
- o_wready  out  1  write accept; = i_cs while out of reset, 0 during reset
- i_waddr  in  ADDR_WIDTH  write address
- i_wdata  in  DATA_WIDTH  write data
- i_wstrb  in  NB  byte-lane write enables; lane k covers bits [8k+7:8k]
- i_rreq_valid  in  1  read request valid
- o_rreq_ready  out  1  read request accept (see Operation)
- i_raddr  in  ADDR_WIDTH  read address
- o_rvalid  out  1  read response valid
- i_rready  in  1  read response accept
- o_rdata  out  DATA_WIDTH  read response data
- o_rperr  out  NB  per-lane parity error for o_rdata (only with DPRAM_PARITY_EN)
- i_wperr_inj  in  1  invert stored parity of written lanes (only with DPRAM_PARITY_EN)

## Operation
- Write accepted on edge where i_wvalid && o_wready; lanes with i_wstrb[k]=1 updated, others retained. Strobe all-zero: accepted, no change.
- Read request accepted on edge where i_rreq_valid && o_rreq_ready; memory read into a pending stage (pend), landing in response buffer next cycle.
- Response buffer: 2-entry FIFO, count 0..2; o_rvalid = (count != 0); o_rdata = head entry; pop on o_rvalid && i_rready.
- occ = count + pend. o_rreq_ready = i_cs && (occ < 2 || (o_rvalid && i_rready)); 0 during reset. Buffer never overflows; responses returned in request order.
- Collision (write and read accepted same edge, i_waddr == i_raddr): RW_MODE 0 returns pre-write word; RW_MODE 1 returns per lane i_wstrb[k] ? i_wdata lane : old lane.
- i_cs low: both readys 0; pending and buffered responses still drain via i_rready.
- Memory contents not reset; unwritten locations read X in simulation.

## Timing
- Reset (asynchronous assert): o_rvalid=0, o_rdata=0, count=0, pend=0, o_rperr=0, o_wready=0, o_rreq_ready=0. Any in-flight/buffered responses discarded.
- Write-to-read: write accepted edge N, read accepted edge ≥N+1 returns new data; same edge N follows RW_MODE.
- Read latency: request accepted edge N -> o_rvalid=1 with data after edge N+1 (one cycle), if buffer empty ahead of it.
- Throughput: one read per cycle sustained while i_rready=1; one write per cycle always while i_cs=1.
- o_rdata/o_rvalid stable while o_rvalid && !i_rready.

## Configuration
- DPRAM_PARITY_EN defined: one even-parity bit stored per byte lane (updated only for strobed lanes); i_wperr_inj=1 stores inverted parity for strobed lanes; o_rperr[k]=1 when lane k parity mismatches, registered alongside and popped with o_rdata.
- Undefined: no parity storage, o_rperr and i_wperr_inj ports absent, memory is DATA_WIDTH wide.

## Test plan
- Reset, write 0xDEADBEEF @3 strobe 0xF, read @3 with i_rready=1 -> o_rvalid one cycle after accept, o_rdata=0xDEADBEEF.
- Write 0x11223344 @5, then 0xAABBCCDD @5 strobe 0x5 -> read @5 returns 0x11BB33DD.
- Hold i_rready=0, issue reads @0,@1,@2 back-to-back -> two accepted, o_rreq_ready=0 thereafter; release i_rready -> data @0 then @1 in order, third read then accepted; streaming with i_rready=1 sustains one response/cycle.
- @7 holds 0x00000000; same-edge write 0xCAFEF00D strobe 0x3 and read @7 -> RW_MODE 0 returns 0x00000000, RW_MODE 1 returns 0x0000F00D.
- i_cs=0 with i_wvalid/i_rreq_valid high -> both readys 0, memory unchanged; assert i_rst low with 2 responses buffered -> o_rvalid=0 immediately, nothing returned after release.
- DPRAM_PARITY_EN: write 0x12345678 @2 with i_wperr_inj=1 strobe 0x2 -> read @2 gives o_rperr=0x2, data 0x12345678; rewrite without inject -> o_rperr=0x0.

Source files
------------

// File: rtl/dpram_hs.sv
// dpram_hs: simple-dual-port RAM with valid/ready write and read-request ports,
// byte-write strobes and a registered read-response path with 2-entry buffering.
//
// Optional feature macro: DPRAM_PARITY_EN adds one even-parity bit per byte lane,
// the o_rperr output and the i_wperr_inj input.
//
// Ports:
//   i_clk, i_rst               clock (rising edge), asynchronous active-low reset
//   i_cs                       chip select; gates acceptance on both ports
//   i_wvalid/o_wready          write handshake; i_waddr, i_wdata, i_wstrb
//   i_rreq_valid/o_rreq_ready  read-request handshake; i_raddr
//   o_rvalid/i_rready          read-response handshake; o_rdata (+ o_rperr)
//
// Parameters: ADDR_WIDTH (depth = 2**ADDR_WIDTH), DATA_WIDTH (multiple of 8),
// RW_MODE same-edge same-address collision policy (0 read-first, 1 write-first).
module dpram_hs #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RW_MODE    = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_cs,
  input  logic                    i_wvalid,
  output logic                    o_wready,
  input  logic [ADDR_WIDTH-1:0]   i_waddr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic                    i_rreq_valid,
  output logic                    o_rreq_ready,
  input  logic [ADDR_WIDTH-1:0]   i_raddr,
  output logic                    o_rvalid,
  input  logic                    i_rready,
  output logic [DATA_WIDTH-1:0]   o_rdata
`ifdef DPRAM_PARITY_EN
  ,
  output logic [DATA_WIDTH/8-1:0] o_rperr,
  input  logic                    i_wperr_inj
`endif
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned Depth = 1 << ADDR_WIDTH;
`ifdef DPRAM_PARITY_EN
  // Response entries carry {perr, data}.
  localparam int unsigned EW = DATA_WIDTH + NB;
`else
  localparam int unsigned EW = DATA_WIDTH;
`endif

  logic [DATA_WIDTH-1:0] mem [Depth];

  logic          wr_acc, rd_acc, pop;
  logic [1:0]    cnt_q;
  logic [1:0]    occ;
  logic          pend_q;
  logic [EW-1:0] pend_data_q;
  logic [EW-1:0] e0_q, e1_q;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [EW-1:0] rd_entry;
  logic          collide;

  assign o_wready     = i_rst & i_cs;
  assign o_rvalid     = (cnt_q != 2'd0);
  assign pop          = o_rvalid & i_rready;
  // Everything accepted but not yet popped: buffered entries plus the pending read.
  assign occ          = cnt_q + {1'b0, pend_q};
  assign o_rreq_ready = i_rst & i_cs & ((occ < 2'd2) | pop);
  assign wr_acc       = i_wvalid & o_wready;
  assign rd_acc       = i_rreq_valid & o_rreq_ready;
  assign collide      = (RW_MODE == 1) && wr_acc && (i_waddr == i_raddr);

  always_comb begin
    rd_word = mem[i_raddr];
    if (collide) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (i_wstrb[k]) rd_word[8*k +: 8] = i_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (i_wstrb[k]) mem[i_waddr][8*k +: 8] <= i_wdata[8*k +: 8];
      end
    end
  end

`ifdef DPRAM_PARITY_EN
  logic [NB-1:0] par_mem [Depth];
  logic [NB-1:0] rd_par;
  logic [NB-1:0] rd_perr;

  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (i_wstrb[k]) par_mem[i_waddr][k] <= (^i_wdata[8*k +: 8]) ^ i_wperr_inj;
      end
    end
  end

  always_comb begin
    rd_par = par_mem[i_raddr];
    if (collide) begin
      for (int unsigned k = 0; k < NB; k++) begin
        if (i_wstrb[k]) rd_par[k] = (^i_wdata[8*k +: 8]) ^ i_wperr_inj;
      end
    end
    for (int unsigned k = 0; k < NB; k++) begin
      rd_perr[k] = rd_par[k] ^ (^rd_word[8*k +: 8]);
    end
  end

  assign rd_entry = {rd_perr, rd_word};
  assign o_rperr  = e0_q[EW-1:DATA_WIDTH];
`else
  assign rd_entry = rd_word;
`endif

  assign o_rdata = e0_q[DATA_WIDTH-1:0];

  // e0_q is the FIFO head, e1_q the second entry.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      cnt_q       <= 2'd0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      e0_q        <= '0;
      e1_q        <= '0;
    end else begin
      pend_q <= rd_acc;
      if (rd_acc) pend_data_q <= rd_entry;
      unique case ({pend_q, pop})
        2'b11: begin
          if (cnt_q == 2'd2) begin
            e0_q <= e1_q;
            e1_q <= pend_data_q;
          end else begin
            e0_q <= pend_data_q;
          end
        end
        2'b01: begin
          e0_q  <= e1_q;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b10: begin
          if (cnt_q == 2'd0) e0_q <= pend_data_q;
          else               e1_q <= pend_data_q;
          cnt_q <= cnt_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dpram_hs.sv
module tb_dpram_hs;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int NB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, cs, wvalid, rreq_valid, rready, wperr_inj;
  logic [AW-1:0] waddr, raddr;
  logic [DW-1:0] wdata;
  logic [NB-1:0] wstrb;
  logic          wready [2];
  logic          rreq_ready [2];
  logic          rvalid [2];
  logic [DW-1:0] rdata [2];
`ifdef DPRAM_PARITY_EN
  logic [NB-1:0] rperr [2];
`endif

  dpram_hs #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RW_MODE(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_cs(cs),
    .i_wvalid(wvalid), .o_wready(wready[0]), .i_waddr(waddr), .i_wdata(wdata), .i_wstrb(wstrb),
    .i_rreq_valid(rreq_valid), .o_rreq_ready(rreq_ready[0]), .i_raddr(raddr),
    .o_rvalid(rvalid[0]), .i_rready(rready), .o_rdata(rdata[0])
`ifdef DPRAM_PARITY_EN
    , .o_rperr(rperr[0]), .i_wperr_inj(wperr_inj)
`endif
  );

  dpram_hs #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RW_MODE(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_cs(cs),
    .i_wvalid(wvalid), .o_wready(wready[1]), .i_waddr(waddr), .i_wdata(wdata), .i_wstrb(wstrb),
    .i_rreq_valid(rreq_valid), .o_rreq_ready(rreq_ready[1]), .i_raddr(raddr),
    .o_rvalid(rvalid[1]), .i_rready(rready), .o_rdata(rdata[1])
`ifdef DPRAM_PARITY_EN
    , .o_rperr(rperr[1]), .i_wperr_inj(wperr_inj)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a flat memory plus one queue of outstanding responses per
  // instance; a response becomes visible two model cycles after its accept edge.
  typedef struct {
    logic [DW-1:0] data;
    logic [NB-1:0] perr;
    int            avail;
  } rsp_t;

  logic [DW-1:0] ref_mem [16];
  logic [NB-1:0] ref_par [16];
  rsp_t q0[$];
  rsp_t q1[$];
  int   cyc = 0;

  function automatic logic [NB-1:0] lane_par(input logic [DW-1:0] d);
    logic [NB-1:0] p;
    for (int k = 0; k < NB; k++) p[k] = ^d[8*k +: 8];
    return p;
  endfunction

  always @(posedge clk) begin : model
    logic vis, wacc, racc, pop;
    rsp_t r0, r1;
    logic [NB-1:0] p0, p1;
    if (!rst) begin
      q0.delete();
      q1.delete();
    end else begin
      vis = 1'b0;
      if (q0.size() > 0) vis = (q0[0].avail <= cyc);
      pop  = vis && rready;
      wacc = cs && wvalid;
      racc = cs && rreq_valid && ((q0.size() < 2) || pop);
      if (racc) begin
        r0.data = ref_mem[raddr];
        p0      = ref_par[raddr];
        r1.data = r0.data;
        p1      = p0;
        if (wacc && waddr == raddr) begin
          for (int k = 0; k < NB; k++) begin
            if (wstrb[k]) begin
              r1.data[8*k +: 8] = wdata[8*k +: 8];
              p1[k] = (^wdata[8*k +: 8]) ^ wperr_inj;
            end
          end
        end
        r0.perr  = p0 ^ lane_par(r0.data);
        r1.perr  = p1 ^ lane_par(r1.data);
        r0.avail = cyc + 2;
        r1.avail = cyc + 2;
      end
      if (pop) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
      end
      if (racc) begin
        q0.push_back(r0);
        q1.push_back(r1);
      end
      if (wacc) begin
        for (int k = 0; k < NB; k++) begin
          if (wstrb[k]) begin
            ref_mem[waddr][8*k +: 8] = wdata[8*k +: 8];
            ref_par[waddr][k] = (^wdata[8*k +: 8]) ^ wperr_inj;
          end
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin : compare
    logic ev0, ev1;
    ev0 = 1'b0;
    ev1 = 1'b0;
    if (rst && q0.size() > 0) ev0 = (q0[0].avail <= cyc);
    if (rst && q1.size() > 0) ev1 = (q1[0].avail <= cyc);
    check("m0_rvalid", 64'(rvalid[0]), 64'(ev0));
    check("m1_rvalid", 64'(rvalid[1]), 64'(ev1));
    check("m0_wready", 64'(wready[0]), 64'(rst && cs));
    check("m1_wready", 64'(wready[1]), 64'(rst && cs));
    check("m0_rreq_ready", 64'(rreq_ready[0]),
          64'(rst && cs && ((q0.size() < 2) || (ev0 && rready))));
    check("m1_rreq_ready", 64'(rreq_ready[1]),
          64'(rst && cs && ((q1.size() < 2) || (ev1 && rready))));
    if (ev0) check("m0_rdata", 64'(rdata[0]), 64'(q0[0].data));
    if (ev1) check("m1_rdata", 64'(rdata[1]), 64'(q1[0].data));
`ifdef DPRAM_PARITY_EN
    if (ev0) check("m0_rperr", 64'(rperr[0]), 64'(q0[0].perr));
    if (ev1) check("m1_rperr", 64'(rperr[1]), 64'(q1[0].perr));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] s);
    wvalid = 1'b1;
    waddr  = a;
    wdata  = d;
    wstrb  = s;
    tick();
    wvalid = 1'b0;
  endtask

  // Single read with i_rready high; returns once the response is visible.
  task automatic rd(input logic [AW-1:0] a);
    rready     = 1'b1;
    rreq_valid = 1'b1;
    raddr      = a;
    tick();
    rreq_valid = 1'b0;
    tick();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst = 1'b0; cs = 1'b0; wvalid = 1'b0; rreq_valid = 1'b0; rready = 1'b0;
    wperr_inj = 1'b0; waddr = '0; raddr = '0; wdata = '0; wstrb = '0;
    #2;
    check("reset_rvalid", 64'(rvalid[0]), 64'd0);
    check("reset_rdata", 64'(rdata[0]), 64'd0);
    check("reset_wready", 64'(wready[0]), 64'd0);
    check("reset_rreq_ready", 64'(rreq_ready[0]), 64'd0);
    tick(); tick();
    rst = 1'b1;
    cs  = 1'b1;
    tick();

    // Basic write then read, one-cycle latency.
    wr(4'd3, 32'hDEADBEEF, 4'hF);
    rready = 1'b1; rreq_valid = 1'b1; raddr = 4'd3;
    tick();
    rreq_valid = 1'b0;
    check("lat_not_yet", 64'(rvalid[0]), 64'd0);
    tick();
    check("lat_rvalid", 64'(rvalid[0]), 64'd1);
    check("lat_rdata", 64'(rdata[0]), 64'hDEADBEEF);
    tick();

    // Partial strobe.
    wr(4'd5, 32'h11223344, 4'hF);
    wr(4'd5, 32'hAABBCCDD, 4'h5);
    rd(4'd5);
    check("strobe_rdata", 64'(rdata[0]), 64'h11BB33DD);
    tick();

    // Backpressure.
    wr(4'd0, 32'h000000A0, 4'hF);
    wr(4'd1, 32'h000000A1, 4'hF);
    wr(4'd2, 32'h000000A2, 4'hF);
    wr(4'd7, 32'h00000000, 4'hF);
    rready = 1'b0; rreq_valid = 1'b1; raddr = 4'd0;
    tick();
    raddr = 4'd1;
    tick();
    raddr = 4'd2;
    check("bp_full_ready", 64'(rreq_ready[0]), 64'd0);
    tick();
    check("bp_still_full", 64'(rreq_ready[0]), 64'd0);
    check("bp_head0", 64'(rdata[0]), 64'h000000A0);
    rready = 1'b1;
    #1;
    check("bp_pop_ready", 64'(rreq_ready[0]), 64'd1);
    tick();
    rreq_valid = 1'b0;
    check("bp_head1", 64'(rdata[0]), 64'h000000A1);
    tick();
    check("bp_head2", 64'(rdata[0]), 64'h000000A2);
    tick();
    check("bp_drained", 64'(rvalid[0]), 64'd0);

    // Streaming at one response per cycle.
    rreq_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      raddr = 4'(i % 3);
      tick();
      if (i >= 1) check("stream_rvalid", 64'(rvalid[0]), 64'd1);
    end
    rreq_valid = 1'b0;
    tick(); tick(); tick();

    // Same-edge collision on @7 (holds zero).
    wvalid = 1'b1; waddr = 4'd7; wdata = 32'hCAFEF00D; wstrb = 4'h3;
    rreq_valid = 1'b1; raddr = 4'd7;
    tick();
    wvalid = 1'b0; rreq_valid = 1'b0;
    tick();
    check("coll_mode0", 64'(rdata[0]), 64'h00000000);
    check("coll_mode1", 64'(rdata[1]), 64'h0000F00D);
    tick();

    // Chip select low: nothing accepted.
    cs = 1'b0; wvalid = 1'b1; waddr = 4'd3; wdata = 32'h0; wstrb = 4'hF;
    rreq_valid = 1'b1; raddr = 4'd3;
    #1;
    check("cs_wready", 64'(wready[0]), 64'd0);
    check("cs_rreq_ready", 64'(rreq_ready[0]), 64'd0);
    tick(); tick();
    wvalid = 1'b0; rreq_valid = 1'b0; cs = 1'b1;
    rd(4'd3);
    check("cs_mem_kept", 64'(rdata[0]), 64'hDEADBEEF);
    tick();

    // Reset with two responses buffered.
    rready = 1'b0; rreq_valid = 1'b1; raddr = 4'd0;
    tick();
    raddr = 4'd1;
    tick();
    rreq_valid = 1'b0;
    tick();
    check("rst_pre_rvalid", 64'(rvalid[0]), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rst_async_rvalid", 64'(rvalid[0]), 64'd0);
    check("rst_async_rdata", 64'(rdata[0]), 64'd0);
    check("rst_async_rreq_ready", 64'(rreq_ready[0]), 64'd0);
    tick();
    rst = 1'b1;
    rready = 1'b1;
    tick(); tick(); tick();
    check("rst_nothing_after", 64'(rvalid[0]), 64'd0);

`ifdef DPRAM_PARITY_EN
    wr(4'd2, 32'h12345678, 4'hF);
    wperr_inj = 1'b1;
    wr(4'd2, 32'h12345678, 4'h2);
    wperr_inj = 1'b0;
    rd(4'd2);
    check("par_inj_data", 64'(rdata[0]), 64'h12345678);
    check("par_inj_perr", 64'(rperr[0]), 64'h2);
    tick();
    wr(4'd2, 32'h12345678, 4'hF);
    rd(4'd2);
    check("par_clean_perr", 64'(rperr[0]), 64'h0);
    tick();
`endif

    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
